seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for the 4-digit 7-segment display. It drives the
//   2-bit select of the active-low 2-to-4 digit decoder and presents the BCD nibble
//   for that digit to the segment encoder. A guard gap between digits removes ghosting.
//   New values are double-buffered and applied only at a frame boundary, so a digit
//   never tears mid-frame.
// PARAMETERS
//   DIV    100000  clock cycles each digit is lit (SHOW phase); must be >= 1
//   GUARD  1000    blanked clock cycles after each digit (GUARD phase); 0 skips the phase
// PORTS
//   clk         in   1   system clock; all state changes on the rising edge
//   rst         in   1   asynchronous, active-high reset
//   en          in   1   scan enable; 0 = display off
//   load        in   1   1-cycle strobe: capture value/dig_en into the pending buffer
//   value       in   16  four BCD nibbles; digit k = value[4k+3:4k]
//   dig_en      in   4   per-digit enable; 0 blanks that digit
//   sel         out  2   digit select to the 2-to-4 decoder
//   nibble      out  4   active_value[4*sel +: 4]
//   blank       out  1   1 = segments off (encoder forces all segments inactive)
//   frame_tick  out  1   1-cycle pulse when sel wraps from 3 to 0
// BEHAVIOUR
//   Reset (async): state=OFF, sel=0, blank=1, nibble=0, frame_tick=0, counter=0,
//     active/pending regs=0, pend_valid=0.
//   Registers: pending {value,dig_en} + pend_valid; active {value,dig_en}.
//   load=1 writes pending and sets pend_valid (last load wins).
//   Commit (pending->active, clear pend_valid) happens on:
//     (a) any OFF cycle with pend_valid=1, or (b) the 3->0 wrap edge.
//     If load=1 on a commit edge, value/dig_en go straight to active and pend_valid stays 0.
//   FSM, one counter of width $clog2(max(DIV,GUARD)+1):
//     OFF   : blank=1, sel=0, cnt=0. When en=1 -> SHOW on the next edge, cnt=0.
//     SHOW  : blank = ~active_dig_en[sel]. cnt counts 0..DIV-1; at DIV-1 -> GUARD
//             (or, if GUARD=0, advance directly), cnt=0.
//     GUARD : blank=1, sel held. cnt counts 0..GUARD-1; at GUARD-1 -> SHOW with
//             sel = sel+1 (mod 4), cnt=0.
//   Digit slot = DIV+GUARD cycles; frame = 4*(DIV+GUARD) cycles.
//   Wrap: the advance edge with sel 3->0 asserts frame_tick for exactly that next cycle
//     and performs commit (b). The nibble shown in the new slot reflects the committed value.
//   en=0 in SHOW/GUARD: next edge -> OFF (sel=0, blank=1, cnt=0), no frame_tick.
//     Re-enable always restarts at sel=0 with a full DIV slot.
//   nibble is combinational from active and sel (no extra latency); blank, sel and
//     frame_tick are registered.
// TESTING (bench DIV=4, GUARD=1)
//   rst pulsed between clock edges -> sel=0, blank=1, nibble=0, frame_tick=0 at once, no edge needed.
//   en=0, load value=16'h1234, dig_en=4'hF; then en=1 -> sel 0,1,2,3 with nibble 4,3,2,1;
//     blank=0 for 4 cycles, then 1 for 1 cycle per slot; frame_tick every 20 cycles.
//   Running 16'h1234; load 16'h5678 while sel=1 -> slots 2,3 still show 2,1; after wrap
//     sel=0 shows 8 and frame_tick=1.
//   dig_en=4'b0011 -> blank=1 during the whole of slots 2 and 3; slots 0 and 1 lit normally.
//   en dropped during sel=2 SHOW -> next cycle sel=0, blank=1; en=1 again -> sel=0 lit for 4 cycles.
//   load on the same edge as the 3->0 wrap with 16'h9999 -> sel=0 slot shows 9 immediately.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Walks the digit select through slots of DIV lit cycles followed by GUARD
// blanked cycles. Display data is double-buffered so that a new value only
// takes effect at a frame boundary, or immediately while the display is off.
module seg_scan_ctrl #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned GUARD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dig_en,
    output logic [1:0]  sel,
    output logic [3:0]  nibble,
    output logic        blank,
    output logic        frame_tick
);

    // The single counter must reach the larger of the two phase lengths.
    localparam int unsigned MAX_CNT = (DIV > GUARD) ? DIV : GUARD;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD > 0) ? CW'(GUARD - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        GUARD_PH = 2'd2
    } scan_state_t;

    scan_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    sel_d;
    logic          blank_d;
    logic          wrap;
    logic          commit;

    logic [15:0]   act_value, act_value_d;
    logic [3:0]    act_dig_en, act_dig_en_d;
    logic [15:0]   pend_value, pend_value_d;
    logic [3:0]    pend_dig_en, pend_dig_en_d;
    logic          pend_valid, pend_valid_d;

    // Scan state, counter and the registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            cnt        <= '0;
            sel        <= 2'd0;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sel        <= sel_d;
            blank      <= blank_d;
            frame_tick <= wrap;
        end
    end

    // Next-state logic: phase sequencing, digit advance and frame wrap detection.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sel_d   = sel;
        wrap    = 1'b0;
        case (state)
            OFF: begin
                sel_d = 2'd0;
                cnt_d = '0;
                if (en) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_d = OFF;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (GUARD == 0) begin
                        sel_d = sel + 2'd1;
                        wrap  = (sel == 2'd3);
                    end else begin
                        state_d = GUARD_PH;
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            GUARD_PH: begin
                if (!en) begin
                    state_d = OFF;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt == GUARD_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    sel_d   = sel + 2'd1;
                    wrap    = (sel == 2'd3);
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = OFF;
                sel_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer update: a commit moves pending (or a same-cycle load) into active.
    always_comb begin
        act_value_d   = act_value;
        act_dig_en_d  = act_dig_en;
        pend_value_d  = pend_value;
        pend_dig_en_d = pend_dig_en;
        pend_valid_d  = pend_valid;
        commit        = ((state == OFF) && pend_valid) || wrap;
        if (commit) begin
            pend_valid_d = 1'b0;
            if (load) begin
                act_value_d  = value;
                act_dig_en_d = dig_en;
            end else begin
                act_value_d  = pend_value;
                act_dig_en_d = pend_dig_en;
            end
        end else if (load) begin
            pend_value_d  = value;
            pend_dig_en_d = dig_en;
            pend_valid_d  = 1'b1;
        end
        blank_d = (state_d == SHOW) ? ~act_dig_en_d[sel_d] : 1'b1;
    end

    // Active and pending display buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_value   <= '0;
            act_dig_en  <= '0;
            pend_value  <= '0;
            pend_dig_en <= '0;
            pend_valid  <= 1'b0;
        end else begin
            act_value   <= act_value_d;
            act_dig_en  <= act_dig_en_d;
            pend_value  <= pend_value_d;
            pend_dig_en <= pend_dig_en_d;
            pend_valid  <= pend_valid_d;
        end
    end

    assign nibble = act_value[{sel, 2'b00} +: 4];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=4, GUARD=1.
// The reference model tracks the position inside a frame as a plain integer
// and derives select, blank and tick from it arithmetically.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int SLOT  = DIV + GUARD;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dig_en;
    logic [1:0]  sel;
    logic [3:0]  nibble;
    logic        blank;
    logic        frame_tick;

    int checks;
    int fails;

    seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .dig_en     (dig_en),
        .sel        (sel),
        .nibble     (nibble),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: on/off, position within the frame, buffers.
    logic        m_on;
    int          m_p;
    logic        m_tick;
    logic [15:0] m_act_val;
    logic [3:0]  m_act_en;
    logic [15:0] m_pend_val;
    logic [3:0]  m_pend_en;
    logic        m_pvalid;
    logic        m_wrap;
    logic        m_commit;

    assign m_wrap   = m_on && en && (m_p == FRAME - 1);
    assign m_commit = (!m_on && m_pvalid) || m_wrap;

    // Model update on each clock edge, reset asynchronously.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on       <= 1'b0;
            m_p        <= 0;
            m_tick     <= 1'b0;
            m_act_val  <= '0;
            m_act_en   <= '0;
            m_pend_val <= '0;
            m_pend_en  <= '0;
            m_pvalid   <= 1'b0;
        end else begin
            m_tick <= m_wrap;
            if (m_commit) begin
                m_pvalid <= 1'b0;
                m_act_val <= load ? value : m_pend_val;
                m_act_en  <= load ? dig_en : m_pend_en;
            end else if (load) begin
                m_pend_val <= value;
                m_pend_en  <= dig_en;
                m_pvalid   <= 1'b1;
            end
            if (!en) begin
                m_on <= 1'b0;
                m_p  <= 0;
            end else if (!m_on) begin
                m_on <= 1'b1;
                m_p  <= 0;
            end else begin
                m_p <= (m_p + 1) % FRAME;
            end
        end
    end

    function automatic int expSel();
        return m_on ? (m_p / SLOT) : 0;
    endfunction

    function automatic logic expBlank();
        int s;
        s = expSel();
        return !m_on || ((m_p % SLOT) >= DIV) || !m_act_en[s];
    endfunction

    function automatic logic [3:0] expNibble();
        logic [15:0] v;
        v = m_act_val >> (4 * expSel());
        return v[3:0];
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("model_sel",   16'(sel),        16'(expSel()));
        checkOutput("model_blank", 16'(blank),      16'(expBlank()));
        checkOutput("model_nib",   16'(nibble),     16'(expNibble()));
        checkOutput("model_tick",  16'(frame_tick), 16'(m_tick));
    endtask

    task automatic stepCycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst) compareModel();
        end
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic [15:0] v, input logic [3:0] d);
        en     = e;
        load   = l;
        value  = v;
        dig_en = d;
    endtask

    task automatic pinOutputs(input string name, input logic [1:0] s, input logic [3:0] nb,
                              input logic bl, input logic ft);
        checkOutput({name, "_sel"},   16'(sel),        16'(s));
        checkOutput({name, "_nib"},   16'(nibble),     16'(nb));
        checkOutput({name, "_blank"}, 16'(blank),      16'(bl));
        checkOutput({name, "_tick"},  16'(frame_tick), 16'(ft));
    endtask

    // Directed scenarios followed by a randomized run against the model.
    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
        #1;
        pinOutputs("reset0", 2'd0, 4'h0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        stepCycle(2);

        // Load while off, then enable: digits 4,3,2,1 in slots 0..3.
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'hF);
        stepCycle(1);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        stepCycle(1);
        pinOutputs("s0_start", 2'd0, 4'h4, 1'b0, 1'b0);
        stepCycle(4);
        pinOutputs("s0_guard", 2'd0, 4'h4, 1'b1, 1'b0);
        stepCycle(1);
        pinOutputs("s1", 2'd1, 4'h3, 1'b0, 1'b0);
        stepCycle(5);
        pinOutputs("s2", 2'd2, 4'h2, 1'b0, 1'b0);
        stepCycle(5);
        pinOutputs("s3", 2'd3, 4'h1, 1'b0, 1'b0);
        stepCycle(4);
        pinOutputs("s3_guard", 2'd3, 4'h1, 1'b1, 1'b0);
        stepCycle(1);
        pinOutputs("wrap1", 2'd0, 4'h4, 1'b0, 1'b1);
        stepCycle(5);

        // Mid-frame load during slot 1 waits for the next wrap.
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'hF);
        stepCycle(1);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        stepCycle(4);
        pinOutputs("hold_s2", 2'd2, 4'h2, 1'b0, 1'b0);
        stepCycle(5);
        pinOutputs("hold_s3", 2'd3, 4'h1, 1'b0, 1'b0);
        stepCycle(5);
        pinOutputs("wrap2", 2'd0, 4'h8, 1'b0, 1'b1);

        // Per-digit enables: slots 2 and 3 stay blank.
        applyStimulus(1'b1, 1'b1, 16'h4321, 4'b0011);
        stepCycle(1);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        stepCycle(19);
        pinOutputs("den_s0", 2'd0, 4'h1, 1'b0, 1'b1);
        stepCycle(10);
        pinOutputs("den_s2", 2'd2, 4'h3, 1'b1, 1'b0);
        stepCycle(5);
        pinOutputs("den_s3", 2'd3, 4'h4, 1'b1, 1'b0);

        // Drop enable during slot 2 show, then restart from slot 0.
        stepCycle(16);
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
        stepCycle(1);
        pinOutputs("off", 2'd0, 4'h1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h8765, 4'hF);
        stepCycle(1);
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
        stepCycle(1);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            stepCycle(1);
            pinOutputs("restart", 2'd0, 4'h5, 1'b0, 1'b0);
        end
        stepCycle(1);
        pinOutputs("restart_guard", 2'd0, 4'h5, 1'b1, 1'b0);

        // Load coinciding with the wrap edge goes straight to active.
        stepCycle(15);
        applyStimulus(1'b1, 1'b1, 16'h9999, 4'hF);
        stepCycle(1);
        pinOutputs("wrap_load", 2'd0, 4'h9, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        stepCycle(1);
        pinOutputs("wrap_load_hold", 2'd0, 4'h9, 1'b0, 1'b0);
        stepCycle(7);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        pinOutputs("reset_mid", 2'd0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
        #1 rst = 1'b0;
        stepCycle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 96,
                          $urandom_range(0, 99) < 8,
                          16'($urandom()),
                          4'($urandom()));
            stepCycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
